// File: rtl/mips_mc_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB over a ready-handshaked word port.
// Optional mult/div (single EXEC cycle) enabled by defining MIPS_MC_MULDIV_EN.
module mips_mc_core #(
  parameter int D_WIDTH  = 32,
  parameter int A_WIDTH  = 8,
  parameter int NREG     = 32,
  parameter int PROG_LEN = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Str,
  output logic               Done,
  output logic               Err,
  output logic [A_WIDTH-1:0] Addr,
  output logic [D_WIDTH-1:0] WData,
  input  logic [D_WIDTH-1:0] RData,
  output logic               RW,
  output logic               En,
  input  logic               Rdy,
  input  logic [4:0]         DbgSel,
  output logic [D_WIDTH-1:0] DbgData
);

  localparam int RI_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [A_WIDTH-1:0] PC_END = A_WIDTH'(PROG_LEN);

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam logic [5:0] FN_SLL = 6'd0;
  localparam logic [5:0] FN_SRL = 6'd2;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;
`ifdef MIPS_MC_MULDIV_EN
  localparam logic [5:0] FN_MULT = 6'd24;
  localparam logic [5:0] FN_DIV  = 6'd26;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_DONE
  } state_t;

  state_t state, nxt;

  logic [A_WIDTH-1:0] pc, mar;
  logic [31:0]        ir;
  logic [D_WIDTH-1:0] a, b, res;
  logic               err_q;
  logic [D_WIDTH-1:0] rf [NREG];

  logic [5:0]         op, fn;
  logic [4:0]         rs, rt, rd, sh, dest;
  logic [D_WIDTH-1:0] simm, rs_val, rt_val, alu;
  logic               is_r, op_ok, fn_ok, uses_rs, illegal, taken;

  function automatic logic reg_bad(input logic [4:0] idx);
    return {1'b0, idx} >= 6'(NREG);
  endfunction

  assign op   = ir[31:26];
  assign rs   = ir[25:21];
  assign rt   = ir[20:16];
  assign rd   = ir[15:11];
  assign sh   = ir[10:6];
  assign fn   = ir[5:0];
  assign simm = {{(D_WIDTH-16){ir[15]}}, ir[15:0]};
  assign is_r = (op == OP_R);
  assign dest = is_r ? rd : rt;

  // Register reads; indices beyond NREG read as zero.
  always_comb begin
    rs_val  = '0;
    rt_val  = '0;
    DbgData = '0;
    if (!reg_bad(rs))     rs_val  = rf[rs[RI_W-1:0]];
    if (!reg_bad(rt))     rt_val  = rf[rt[RI_W-1:0]];
    if (!reg_bad(DbgSel)) DbgData = rf[DbgSel[RI_W-1:0]];
  end

  always_comb begin
    op_ok = 1'b0;
    case (op)
      OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_HALT: op_ok = 1'b1;
      default: op_ok = 1'b0;
    endcase
    fn_ok = 1'b0;
    case (fn)
      FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: fn_ok = 1'b1;
`ifdef MIPS_MC_MULDIV_EN
      FN_MULT, FN_DIV: fn_ok = 1'b1;
`endif
      default: fn_ok = 1'b0;
    endcase
    // Shifts take their source from rt; rs is a don't-care field there.
    uses_rs = is_r ? !(fn == FN_SLL || fn == FN_SRL) : (op != OP_HALT);
    illegal = !op_ok || (is_r && !fn_ok)
           || (uses_rs && reg_bad(rs))
           || ((op != OP_HALT) && reg_bad(rt))
           || (is_r && reg_bad(rd));
  end

  always_comb begin
    alu = a + simm;
    if (is_r) begin
      case (fn)
        FN_SLL: alu = b << sh;
        FN_SRL: alu = b >> sh;
        FN_ADD: alu = a + b;
        FN_SUB: alu = a - b;
        FN_AND: alu = a & b;
        FN_OR:  alu = a | b;
        FN_SLT: begin
          alu    = '0;
          alu[0] = ($signed(a) < $signed(b));
        end
`ifdef MIPS_MC_MULDIV_EN
        FN_MULT: alu = $signed(a) * $signed(b);
        FN_DIV:  alu = (b == '0) ? '1 : $signed(a) / $signed(b);
`endif
        default: alu = '0;
      endcase
    end
  end

  assign taken = (op == OP_BEQ) ? (a == b) : (a != b);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt   = state;
    En    = 1'b0;
    RW    = 1'b0;
    Addr  = '0;
    WData = '0;
    case (state)
      S_IDLE: if (Str) nxt = S_FETCH;
      S_FETCH: begin
        if (pc == PC_END) begin
          nxt = S_DONE;
        end else begin
          En   = 1'b1;
          Addr = pc;
          if (Rdy) nxt = S_DECODE;
        end
      end
      S_DECODE: nxt = (op == OP_HALT || illegal) ? S_DONE : S_EXEC;
      S_EXEC: begin
        if (op == OP_LW || op == OP_SW)        nxt = S_MEM;
        else if (op == OP_BEQ || op == OP_BNE) nxt = S_FETCH;
        else                                   nxt = S_WB;
      end
      S_MEM: begin
        En    = 1'b1;
        RW    = (op == OP_SW);
        Addr  = mar;
        WData = (op == OP_SW) ? b : '0;
        if (Rdy) nxt = (op == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB:   nxt = S_FETCH;
      S_DONE: if (Str) nxt = S_FETCH;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc    <= '0;
      mar   <= '0;
      ir    <= '0;
      a     <= '0;
      b     <= '0;
      res   <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Str) begin
            pc    <= '0;
            err_q <= 1'b0;
          end
        end
        S_FETCH: begin
          if (pc != PC_END && Rdy) begin
            ir <= RData[31:0];
            pc <= pc + A_WIDTH'(1);
          end
        end
        S_DECODE: begin
          a <= rs_val;
          b <= rt_val;
          if (illegal) err_q <= 1'b1;
        end
        S_EXEC: begin
          res <= alu;
          mar <= A_WIDTH'(a + simm);
          if ((op == OP_BEQ || op == OP_BNE) && taken) pc <= pc + simm[A_WIDTH-1:0];
        end
        S_MEM: if (Rdy && op == OP_LW) res <= RData;
        S_WB:  if (dest != 5'd0) rf[dest[RI_W-1:0]] <= res;
        default: ;
      endcase
    end
  end

  assign Done = (state == S_DONE);
  assign Err  = (state == S_DONE) && err_q;

endmodule
